// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: buffered receive stage between the buart receiver and the
// CPU data bus. Bytes are drained from buart into a circular FIFO. The CPU
// sees one data/status word (a read pops a byte) and one control word. A
// level interrupt is raised on a fill threshold, on an idle timeout with
// data waiting, or on overflow.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2     = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int THRESH_RESET   = 8
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        uart_valid,
  input  logic [7:0]  uart_data,
  output logic        uart_ack,
  input  logic        sel,
  input  logic        ctl_sel,
  input  logic        rd,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam int          CW        = DEPTH_LOG2 + 1;
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);

  // Storage and pointers
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count;

  // Status / control state
  logic        overflow;
  logic        to_flag;
  logic        ien;
  logic [4:0]  thresh;
  logic [15:0] idle;
  logic        hold;

  // Per-cycle strobes
  logic        push_req;
  logic        ctl_wr;
  logic        flush;
  logic        ovf_clr;
  logic        not_empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        ovf_set;
  logic        idle_clr;
  logic [4:0]  thr_eff;
  logic [4:0]  cnt5;
  logic        level_hit;
  logic        rd_load;
  logic [31:0] rd_word;

  // wdata/we bits with no function in the control word
  logic unused_bits;
  assign unused_bits = ^{wdata[31:13], wdata[7:3], we[3:2]};

  // Decode bus strobes and FIFO events for this cycle. A byte is acked
  // whenever buart offers it outside the post-ack holdoff; whether it is
  // stored depends on space, a same-cycle pop and flush.
  always_comb begin
    push_req  = uart_valid & ~uart_ack & ~hold;
    ctl_wr    = ctl_sel & (|we);
    flush     = ctl_wr & we[0] & wdata[1];
    ovf_clr   = ctl_wr & we[0] & wdata[0];
    not_empty = (count != '0);
    full      = (count == CW'(DEPTH));
    pop       = sel & rd & not_empty & ~flush;
    push      = push_req & ~flush & (~full | pop);
    ovf_set   = push_req & ~flush & full & ~pop;
    idle_clr  = flush | push | pop | ~not_empty;
    thr_eff   = (thresh == 5'd0) ? 5'd1 : thresh;
    cnt5      = 5'(count);
    level_hit = (6'(count) >= {1'b0, thr_eff});
    rd_load   = rd & (sel | ctl_sel);
  end

  // Assemble the read word; the data/status word takes priority over the
  // control word if both decodes are asserted.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_word = '0;
    if (sel) begin
      rd_word[7:0]   = not_empty ? mem[rd_ptr] : 8'd0;
      rd_word[8]     = not_empty;
      rd_word[9]     = overflow;
      rd_word[10]    = to_flag;
      rd_word[11]    = irq;
      rd_word[20:16] = cnt5;
    end else if (ctl_sel) begin
      rd_word[2]     = ien;
      rd_word[12:8]  = thresh;
      rd_word[20:16] = cnt5;
    end
  end

  // Byte storage, written at the tail on every accepted push.
  // NOTE: the array has no reset; stale bytes are unreachable because the
  // pointers and count are reset, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    if (resetq && push) mem[wr_ptr] <= uart_data;
  end

  // Pointers, count, flags, idle timer, registers and registered outputs.
  // NOTE: all sequential state uses non-blocking assignment so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      to_flag  <= 1'b0;
      ien      <= 1'b0;
      thresh   <= 5'(THRESH_RESET);
      idle     <= '0;
      hold     <= 1'b0;
      uart_ack <= 1'b0;
      irq      <= 1'b0;
      rdata    <= '0;
    end else begin
      uart_ack <= push_req;
      hold     <= uart_ack;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end

      // A new overflow in the same cycle as a clear is kept.
      overflow <= (overflow & ~ovf_clr) | ovf_set;

      if (idle_clr)              idle <= '0;
      else if (idle != 16'hFFFF) idle <= idle + 16'd1;

      if (flush || pop)                                 to_flag <= 1'b0;
      else if (!push && not_empty && idle == IDLE_LAST) to_flag <= 1'b1;

      if (ctl_wr && we[0]) ien    <= wdata[2];
      if (ctl_wr && we[1]) thresh <= wdata[12:8];

      irq <= ien & (level_hit | to_flag | overflow);

      if (rd_load) rdata <= rd_word;
    end
  end

endmodule
